// File: rtl/opregister_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opregister_pkg
// Description : Op code constants, FSM state encoding and op-class helpers
//               shared by the op-register datapath and its control.
// Revision    : 1.0 - initial release
// ============================================================================
package opregister_pkg;

  localparam logic [3:0] C_OP_NOP  = 4'd0;
  localparam logic [3:0] C_OP_LOAD = 4'd1;
  localparam logic [3:0] C_OP_CLR  = 4'd2;
  localparam logic [3:0] C_OP_INC  = 4'd3;
  localparam logic [3:0] C_OP_DEC  = 4'd4;
  localparam logic [3:0] C_OP_ADD  = 4'd5;
  localparam logic [3:0] C_OP_SUB  = 4'd6;
  localparam logic [3:0] C_OP_AND  = 4'd7;
  localparam logic [3:0] C_OP_OR   = 4'd8;
  localparam logic [3:0] C_OP_XOR  = 4'd9;
  localparam logic [3:0] C_OP_NOT  = 4'd10;
  localparam logic [3:0] C_OP_SHL  = 4'd11;
  localparam logic [3:0] C_OP_SHR  = 4'd12;
  localparam logic [3:0] C_OP_ROL  = 4'd13;
  localparam logic [3:0] C_OP_ROR  = 4'd14;
  localparam logic [3:0] C_OP_RSV  = 4'd15;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Ops that honour the repeat count.
  function automatic logic is_repeatable(input logic [3:0] op);
    return (op == C_OP_INC) || (op == C_OP_DEC) || (op == C_OP_SHL) ||
           (op == C_OP_SHR) || (op == C_OP_ROL) || (op == C_OP_ROR);
  endfunction

  // Ops whose application rewrites the carry flag.
  function automatic logic sets_carry(input logic [3:0] op);
    return is_repeatable(op) || (op == C_OP_ADD) || (op == C_OP_SUB) ||
           (op == C_OP_CLR);
  endfunction

  // Ops that count as real work and therefore produce a done pulse.
  function automatic logic is_real_op(input logic [3:0] op);
    return (op != C_OP_NOP) && (op != C_OP_RSV);
  endfunction

endpackage : opregister_pkg
`default_nettype wire

// File: rtl/opregister_alu.sv
`default_nettype none
// ============================================================================
// Module      : opregister_alu
// Description : Combinational single-application datapath: one op applied
//               once to a register value, producing new value and carry.
// Revision    : 1.0 - initial release
// ============================================================================
module opregister_alu
  import opregister_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] data,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // One extra bit on each arithmetic path captures carry-out / borrow.
  logic [WIDTH:0] w_add;
  logic [WIDTH:0] w_sub;
  logic [WIDTH:0] w_inc;
  logic [WIDTH:0] w_dec;

  assign w_add = {1'b0, value} + {1'b0, data};
  assign w_sub = {1'b0, value} - {1'b0, data};
  assign w_inc = {1'b0, value} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec = {1'b0, value} - {{WIDTH{1'b0}}, 1'b1};

  // Op decode; non-carry ops report 0 and the caller ignores it.
  always_comb begin
    result = value;
    carry  = 1'b0;
    case (op)
      C_OP_LOAD: result = data;
      C_OP_CLR:  result = '0;
      C_OP_INC:  {carry, result} = w_inc;
      C_OP_DEC:  {carry, result} = w_dec;
      C_OP_ADD:  {carry, result} = w_add;
      C_OP_SUB:  {carry, result} = w_sub;
      C_OP_AND:  result = value & data;
      C_OP_OR:   result = value | data;
      C_OP_XOR:  result = value ^ data;
      C_OP_NOT:  result = ~value;
      C_OP_SHL: begin
        result = {value[WIDTH-2:0], 1'b0};
        carry  = value[WIDTH-1];
      end
      C_OP_SHR: begin
        result = {1'b0, value[WIDTH-1:1]};
        carry  = value[0];
      end
      C_OP_ROL: begin
        result = {value[WIDTH-2:0], value[WIDTH-1]};
        carry  = value[WIDTH-1];
      end
      C_OP_ROR: begin
        result = {value[0], value[WIDTH-1:1]};
        carry  = value[0];
      end
      default: result = value;
    endcase
  end

endmodule : opregister_alu
`default_nettype wire

// File: rtl/param_opregister.sv
`default_nettype none
// ============================================================================
// Module      : param_opregister
// Description : Bank of DEPTH registers with an op engine; repeatable ops
//               run for i_w_count cycles under a two-state FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module param_opregister
  import opregister_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_w_clk,
  input  logic              i_w_reset,
  input  logic [WIDTH-1:0]  i_w_data,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic              i_w_we,
  input  logic              i_w_oe,
  input  logic [3:0]        i_w_opsel,
  input  logic [3:0]        i_w_count,
  output logic [WIDTH-1:0]  o_w_out,
  output logic              o_w_busy,
  output logic              o_w_done,
  output logic              o_w_carry
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_regs [DEPTH];
  logic [3:0]         r_op;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_left;
  logic               r_carry;
  logic               r_done;

  logic [3:0]         w_op;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic               w_apply;
  logic               w_done_next;
  logic               w_start;
  logic [WIDTH-1:0]   w_result;
  logic               w_alu_carry;

  opregister_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .value  (r_regs[w_sel_addr]),
    .data   (i_w_data),
    .op     (w_op),
    .result (w_result),
    .carry  (w_alu_carry)
  );

  // FSM state register; reset aborts any running sequence.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) r_state <= S_IDLE;
    else           r_state <= w_next_state;
  end

  // Next state and op selection: live inputs in IDLE, latched op in RUN.
  always_comb begin
    w_next_state = r_state;
    w_op         = i_w_opsel;
    w_sel_addr   = i_w_addr;
    w_apply      = 1'b0;
    w_done_next  = 1'b0;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_w_we) begin
          w_apply = 1'b1;
          if (is_repeatable(i_w_opsel) && (i_w_count >= 4'd2)) begin
            w_next_state = S_RUN;
            w_start      = 1'b1;
          end else begin
            w_done_next = is_real_op(i_w_opsel);
          end
        end
      end
      S_RUN: begin
        w_op       = r_op;
        w_sel_addr = r_addr;
        w_apply    = 1'b1;
        if (r_left == 4'd1) begin
          w_next_state = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Register bank: one application per cycle to the selected entry.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_apply) begin
      r_regs[w_sel_addr] <= w_result;
    end
  end

  // Sequence latch; r_left counts applications still owed after this edge.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_op   <= C_OP_NOP;
      r_addr <= '0;
      r_left <= 4'd0;
    end else if (w_start) begin
      r_op   <= i_w_opsel;
      r_addr <= i_w_addr;
      r_left <= i_w_count - 4'd1;
    end else if (r_state == S_RUN) begin
      r_left <= r_left - 4'd1;
    end
  end

  // Carry and done flags.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_done_next;
      if (w_apply && sets_carry(w_op)) r_carry <= w_alu_carry;
    end
  end

  assign o_w_out   = i_w_oe ? r_regs[i_w_addr] : {WIDTH{1'bz}};
  assign o_w_busy  = (r_state == S_RUN);
  assign o_w_done  = r_done;
  assign o_w_carry = r_carry;

endmodule : param_opregister
`default_nettype wire

// File: tb/tb_param_opregister.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_opregister
// Description : Self-checking bench: directed scenarios plus random ops,
//               all compared against a behavioural register-bank model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_opregister;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic [1:0] addr;
  logic       we;
  logic       oe;
  logic [3:0] opsel;
  logic [3:0] count;
  wire  [7:0] out;
  wire        busy;
  wire        done;
  wire        carry;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  param_opregister #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .i_w_clk   (clk),
    .i_w_reset (rst),
    .i_w_data  (data),
    .i_w_addr  (addr),
    .i_w_we    (we),
    .i_w_oe    (oe),
    .i_w_opsel (opsel),
    .i_w_count (count),
    .o_w_out   (out),
    .o_w_busy  (busy),
    .o_w_done  (done),
    .o_w_carry (carry)
  );

  always #10 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_regs [4];
  int m_carry, m_busy, m_done, m_op, m_addr, m_left;

  function automatic void m_apply(input int op, input int a, input int d);
    int v;
    int s;
    v = m_regs[a];
    case (op)
      1:  v = d;
      2:  begin v = 0; m_carry = 0; end
      3:  begin m_carry = (v == 255) ? 1 : 0; v = (v + 1) % 256; end
      4:  begin m_carry = (v == 0) ? 1 : 0; v = (v + 255) % 256; end
      5:  begin s = v + d; m_carry = (s > 255) ? 1 : 0; v = s % 256; end
      6:  begin m_carry = (v < d) ? 1 : 0; v = (v - d + 256) % 256; end
      7:  v = v & d;
      8:  v = v | d;
      9:  v = v ^ d;
      10: v = 255 - v;
      11: begin m_carry = v / 128; v = (v * 2) % 256; end
      12: begin m_carry = v % 2; v = v / 2; end
      13: begin m_carry = v / 128; v = (v * 2) % 256 + m_carry; end
      14: begin m_carry = v % 2; v = v / 2 + 128 * m_carry; end
      default: ;
    endcase
    m_regs[a] = v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_carry = 0; m_busy = 0; m_done = 0; m_op = 0; m_addr = 0; m_left = 0;
  endfunction

  int n_app;
  int op_i;
  // Model advances on the same edges as the DUT, reading stable inputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      m_done = 0;
      if (m_busy != 0) begin
        m_apply(m_op, m_addr, 0);
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (we) begin
        op_i  = int'(opsel);
        n_app = (count < 4'd2) ? 1 : int'(count);
        m_apply(op_i, int'(addr), int'(data));
        if ((op_i == 3 || op_i == 4 || (op_i >= 11 && op_i <= 14)) && n_app > 1) begin
          m_busy = 1;
          m_op   = op_i;
          m_addr = int'(addr);
          m_left = n_app - 1;
        end else begin
          m_done = (op_i != 0 && op_i != 15) ? 1 : 0;
        end
      end
    end
  end

  // Every cycle, mid-period: outputs must match the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      if (oe) chk("cyc_out", {24'b0, out}, m_regs[addr]);
      else    chk("cyc_out_z", {31'b0, (out === 8'hzz)}, 32'd1);
      chk("cyc_busy",  {31'b0, busy},  m_busy);
      chk("cyc_done",  {31'b0, done},  m_done);
      chk("cyc_carry", {31'b0, carry}, m_carry);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int o, input int a, input int d, input int c);
    opsel = 4'(o); addr = 2'(a); data = 8'(d); count = 4'(c); we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input string nm, input int a, input int exp);
    addr = 2'(a);
    #1;
    chk(nm, {24'b0, out}, exp);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; oe = 1'b1; data = 8'h00; addr = 2'd0;
    opsel = 4'd0; count = 4'd0;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Reset state on every address, then high impedance.
    for (int i = 0; i < 4; i++) rd("rst_read", i, 0);
    chk("rst_carry", {31'b0, carry}, 0);
    oe = 1'b0;
    #1;
    chk("oe_off_z", {31'b0, (out === 8'hzz)}, 1);
    oe = 1'b1;

    // LOAD and single done pulse.
    do_op(1, 2, 8'hA5, 0);
    chk("load_done", {31'b0, done}, 1);
    rd("load_a2", 2, 8'hA5);
    rd("load_a1", 1, 8'h00);
    tick();
    chk("load_done_off", {31'b0, done}, 0);

    // INC overflow then SUB borrow.
    do_op(1, 0, 8'hFF, 0);
    do_op(3, 0, 0, 0);
    rd("inc_wrap", 0, 8'h00);
    chk("inc_carry", {31'b0, carry}, 1);
    do_op(6, 0, 8'h05, 0);
    rd("sub_val", 0, 8'hFB);
    chk("sub_borrow", {31'b0, carry}, 1);

    // ROL x3 with a LOAD attempted while busy.
    do_op(1, 1, 8'h81, 0);
    opsel = 4'd13; addr = 2'd1; count = 4'd3; we = 1'b1;
    tick();
    chk("rol_busy1", {31'b0, busy}, 1);
    rd("rol_1", 1, 8'h03);
    opsel = 4'd1; data = 8'h55; we = 1'b1;
    tick();
    chk("rol_busy2", {31'b0, busy}, 1);
    chk("rol_nodone", {31'b0, done}, 0);
    rd("rol_2", 1, 8'h06);
    tick();
    we = 1'b0;
    chk("rol_busy_end", {31'b0, busy}, 0);
    chk("rol_done", {31'b0, done}, 1);
    rd("rol_3", 1, 8'h0C);
    tick();
    chk("rol_done_off", {31'b0, done}, 0);
    rd("rol_load_dropped", 1, 8'h0C);

    // SHR x8 aborted by reset.
    do_op(1, 2, 8'hF0, 0);
    opsel = 4'd12; addr = 2'd2; count = 4'd8; we = 1'b1;
    tick();
    we = 1'b0;
    rd("shr_1", 2, 8'h78);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_done", {31'b0, done}, 0);
    chk("abort_carry", {31'b0, carry}, 0);
    for (int i = 0; i < 4; i++) rd("abort_read", i, 0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    rd("abort_after", 2, 0);
    chk("abort_after_busy", {31'b0, busy}, 0);

    // Reserved op and CLR with a large count.
    do_op(1, 3, 8'h33, 0);
    do_op(15, 3, 8'h12, 5);
    chk("rsv_busy", {31'b0, busy}, 0);
    chk("rsv_done", {31'b0, done}, 0);
    rd("rsv_keep", 3, 8'h33);
    do_op(1, 3, 8'hFF, 0);
    do_op(3, 3, 0, 0);
    chk("pre_clr_carry", {31'b0, carry}, 1);
    do_op(2, 3, 0, 9);
    chk("clr_busy", {31'b0, busy}, 0);
    chk("clr_done", {31'b0, done}, 1);
    chk("clr_carry", {31'b0, carry}, 0);
    rd("clr_val", 3, 8'h00);
    tick();
    chk("clr_busy_after", {31'b0, busy}, 0);

    // Random traffic checked by the per-cycle compare.
    for (int k = 0; k < 600; k++) begin
      we    = ($urandom_range(0, 2) == 0);
      opsel = 4'($urandom_range(0, 15));
      addr  = 2'($urandom_range(0, 3));
      data  = 8'($urandom_range(0, 255));
      count = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(0, 2));
      oe    = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_param_opregister
`default_nettype wire
